// File: rtl/riscv_pkg.sv
// Shared core-wide sizing constants used by the writeback path.
package riscv_pkg;
  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
  localparam int unsigned WB_DEPTH  = 4;
  localparam int unsigned WB_CNT_W  = $clog2(WB_DEPTH + 1);
endpackage

// File: rtl/wb_fifo.sv
// Writeback result queue: up to two pushes (push0 first) and one pop per cycle.
module wb_fifo #(
  parameter int unsigned WIDTH = riscv_pkg::WORD_SIZE + riscv_pkg::REG_IDX_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            push0,
  input  logic [WIDTH-1:0]                push0_data,
  input  logic                            push1,
  input  logic [WIDTH-1:0]                push1_data,
  input  logic                            pop,
  output logic                            empty,
  output logic [riscv_pkg::WB_CNT_W-1:0]  count,
  output logic [WIDTH-1:0]                head
);
  localparam int unsigned DEPTH = riscv_pkg::WB_DEPTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = riscv_pkg::WB_CNT_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;

  assign wr_ptr_nxt = wr_ptr + PTR_W'(1);

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      cnt_q  <= cnt_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  // Payload storage carries no reset; push1 is only used alongside push0.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= push0_data;
    if (push1) mem[wr_ptr_nxt] <= push1_data;
  end

  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates ALU/load results into a small queue that drives
// the register-file write port, and tracks pending destinations for hazards.
module wb_unit #(
  parameter  int unsigned WORD_SIZE = riscv_pkg::WORD_SIZE,
  parameter  int unsigned NUM_REGS  = riscv_pkg::NUM_REGS,
  localparam int unsigned REG_IDX_W = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issueValid,
  input  logic [REG_IDX_W-1:0] issueRd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 rs1Busy,
  output logic                 rs2Busy,
  input  logic                 aValid,
  output logic                 aReady,
  input  logic [REG_IDX_W-1:0] aRd,
  input  logic [WORD_SIZE-1:0] aData,
  input  logic                 bValid,
  output logic                 bReady,
  input  logic [REG_IDX_W-1:0] bRd,
  input  logic [WORD_SIZE-1:0] bData,
  output logic                 wCtrl,
  output logic [REG_IDX_W-1:0] wSel,
  output logic [WORD_SIZE-1:0] wData
);
  localparam int unsigned ENT_W = REG_IDX_W + WORD_SIZE;
  localparam int unsigned CNT_W = riscv_pkg::WB_CNT_W;
  localparam int unsigned DEPTH = riscv_pkg::WB_DEPTH;

  logic [CNT_W-1:0]    count;
  logic                empty;
  logic [ENT_W-1:0]    head;
  logic                pop;
  logic                a_push;
  logic                b_push;
  logic                push0;
  logic                push1;
  logic [ENT_W-1:0]    push0_data;
  logic [ENT_W-1:0]    push1_data;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Readiness reserves two slots for A whenever B competes in the same cycle.
  assign bReady = (count <= CNT_W'(DEPTH - 1));
  assign aReady = bValid ? (count <= CNT_W'(DEPTH - 2)) : (count <= CNT_W'(DEPTH - 1));

  assign b_push = bValid && bReady && (bRd != '0);
  assign a_push = aValid && aReady && (aRd != '0);

  // B takes the first slot; A follows in the second slot when both push.
  always_comb begin
    push0      = b_push || a_push;
    push1      = b_push && a_push;
    push0_data = b_push ? {bRd, bData} : {aRd, aData};
    push1_data = {aRd, aData};
  end

  wb_fifo #(.WIDTH(ENT_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (push1_data),
    .pop        (pop),
    .empty      (empty),
    .count      (count),
    .head       (head)
  );

  assign pop             = !empty;
  assign wCtrl           = !empty;
  assign {wSel, wData}   = head;

  // Scoreboard: a new issue wins over a same-cycle retire of that register.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[wSel] = 1'b0;
    if (issueValid && (issueRd != '0)) busy_d[issueRd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) busy_q <= '0;
    else              busy_q <= busy_d;
  end

  assign rs1Busy = busy_q[rs1];
  assign rs2Busy = busy_q[rs2];
endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, meaning data width.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning architectural register count; REG_IDX_W = $clog2(NUM_REGS).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  synchronous clear of queue and scoreboard.
REQ-006 The block SHALL have ports issueValid  input  1 and issueRd  input  REG_IDX_W, meaning instruction issued with destination issueRd.
REQ-007 The block SHALL have ports rs1, rs2  input  REG_IDX_W and rs1Busy, rs2Busy  output  1, meaning hazard query.
REQ-008 The block SHALL have ports aValid in 1, aReady out 1, aRd in REG_IDX_W, aData in WORD_SIZE: ALU result source.
REQ-009 The block SHALL have ports bValid in 1, bReady out 1, bRd in REG_IDX_W, bData in WORD_SIZE: load/multi-cycle result source.
REQ-010 The block SHALL have ports wCtrl out 1, wSel out REG_IDX_W, wData out WORD_SIZE: register-file write port.

Function
REQ-011 Results SHALL be queued in a 4-entry FIFO {rd, data}; count range 0..4.
REQ-012 A source transfer SHALL occur on a cycle where xValid && xReady.
REQ-013 Readiness SHALL use count before any same-cycle pop: bReady = (count <= 3); aReady = bValid ? (count <= 2) : (count <= 3).
REQ-014 On simultaneous A and B transfers, B SHALL be pushed first, then A, in the same cycle.
REQ-015 A transfer with rd == 0 SHALL be accepted but SHALL NOT be pushed.
REQ-016 wCtrl SHALL equal !empty; wSel/wData SHALL equal the FIFO head; no combinational path from any input to wCtrl/wSel/wData.
REQ-017 The head SHALL be popped on every cycle wCtrl = 1; latency from transfer edge to wCtrl = 1 SHALL be one cycle when the FIFO is empty.
REQ-018 Push and pop in the same cycle SHALL be allowed; count SHALL update as count + pushes - pop.
REQ-019 FIFO read/write pointers SHALL wrap modulo 4.
REQ-020 Scoreboard busy[NUM_REGS-1:0]: issueValid && issueRd != 0 SHALL set busy[issueRd] at the clock edge.
REQ-021 A pop SHALL clear busy[wSel] at the clock edge.
REQ-022 Set and clear of the same register in one cycle SHALL leave busy = 1.
REQ-023 busy[0] SHALL always read 0.
REQ-024 rs1Busy = busy[rs1], rs2Busy = busy[rs2], combinational from registered state; a same-cycle issue SHALL NOT bypass into the query.
REQ-025 flush SHALL empty the FIFO and clear all busy bits at the edge, overriding same-cycle push, pop, and issue.

Reset
REQ-026 rst SHALL set count = 0, pointers = 0, and busy = 0, giving wCtrl = 0, rs1Busy = rs2Busy = 0, aReady = bReady = 1.
REQ-027 rst mid-operation SHALL discard queued entries with no write emitted in the following cycle; rst has priority over flush.
REQ-028 FIFO data storage SHALL NOT require reset.

Structure
REQ-029 WORD_SIZE, NUM_REGS, REG_IDX_W, and WB_DEPTH = 4 SHALL live in the shared package riscv_pkg.
REQ-030 The FIFO SHALL be a sub-module wb_fifo with a two-push, one-pop interface; the scoreboard and arbitration SHALL stay in wb_unit.

Verification
REQ-031 Issue rd = 5, then A transfer rd = 5, data = 0xDEADBEEF with an empty FIFO -> next cycle wCtrl = 1, wSel = 5, wData = 0xDEADBEEF; rs1 = 5 gives rs1Busy = 1 until after that edge, then 0.
REQ-032 A (rd = 3, 0x11) and B (rd = 4, 0x22) in the same cycle -> writes on consecutive cycles: rd = 4 / 0x22, then rd = 3 / 0x11.
REQ-033 Hold A and B valid continuously for 6 cycles -> count never exceeds 4, aReady drops at count = 3, entries drain in order with none lost or duplicated.
REQ-034 A transfer rd = 0, data = 0xFFFFFFFF -> wCtrl stays 0; issue rd = 0 -> rs1 = 0 gives rs1Busy = 0.
REQ-035 Issue rd = 7 on the same cycle a queued rd = 7 is popped -> busy[7] remains 1.
REQ-036 3 entries queued, then assert flush (and separately rst) -> next cycle wCtrl = 0, all busy = 0, aReady = bReady = 1.
